// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared types for the multi-cycle RV32I control path.
//               - RV32I major-opcode constants
//               - Control FSM state encoding (ctrl_state_t)
//               - Datapath mux-select encodings
//               - One-hot instruction-class record
//               Build option: MULTICYCLE_CTRL_TRAP_EN adds the TRAP state.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // RV32I major opcodes (instruction bits [6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
`ifdef MULTICYCLE_CTRL_TRAP_EN
        ,
        ST_TRAP   = 3'd5
`endif
    } ctrl_state_t;

    typedef enum logic [1:0] {
        PC_SRC_PLUS4 = 2'd0,   // PC + 4
        PC_SRC_IMM   = 2'd1,   // PC + immediate
        PC_SRC_ALU   = 2'd2    // ALU result with bit 0 cleared
    } pc_src_t;

    typedef enum logic [1:0] {
        SRC_A_RS1  = 2'd0,
        SRC_A_PC   = 2'd1,
        SRC_A_ZERO = 2'd2
    } alu_src_a_t;

    typedef enum logic [1:0] {
        WB_SEL_ALU = 2'd0,
        WB_SEL_MEM = 2'd1,
        WB_SEL_PC4 = 2'd2
    } wb_sel_t;

    typedef enum logic [1:0] {
        ALU_CTRL_ADD    = 2'd0,
        ALU_CTRL_FUNCT  = 2'd1,
        ALU_CTRL_BRANCH = 2'd2
    } alu_ctrl_t;

    localparam logic SRC_B_RS2 = 1'b0;
    localparam logic SRC_B_IMM = 1'b1;

    // Exactly one field is set for any opcode value.
    typedef struct packed {
        logic lui;
        logic auipc;
        logic jal;
        logic jalr;
        logic branch;
        logic load;
        logic store;
        logic op_imm;
        logic op;
        logic fence;
        logic system;
        logic illegal;
    } instr_class_t;

    // SYSTEM opcodes share the unknown-opcode handling.
    function automatic logic is_unsupported(input instr_class_t cls);
        return cls.system | cls.illegal;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_opcode_dec.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_opcode_dec
// Description : Combinational RV32I opcode classifier. Maps the 7-bit major
//               opcode to a one-hot instruction-class record; any encoding
//               outside the supported set raises the illegal field.
// Ports       : i_opcode  in  7   instruction bits [6:0]
//               o_class   out     one-hot instruction class
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_opcode_dec
    import riscv_pkg::*;
(
    input  logic [6:0]   i_opcode,
    output instr_class_t o_class
);

    always_comb begin
        o_class = '0;
        case (i_opcode)
            OPC_LUI:    o_class.lui     = 1'b1;
            OPC_AUIPC:  o_class.auipc   = 1'b1;
            OPC_JAL:    o_class.jal     = 1'b1;
            OPC_JALR:   o_class.jalr    = 1'b1;
            OPC_BRANCH: o_class.branch  = 1'b1;
            OPC_LOAD:   o_class.load    = 1'b1;
            OPC_STORE:  o_class.store   = 1'b1;
            OPC_OP_IMM: o_class.op_imm  = 1'b1;
            OPC_OP:     o_class.op      = 1'b1;
            OPC_FENCE:  o_class.fence   = 1'b1;
            OPC_SYSTEM: o_class.system  = 1'b1;
            default:    o_class.illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB).
//               Drives datapath mux selects, write enables and a
//               ready-handshaked unified memory request; counts retired
//               instructions. Outputs are combinational from state and IR
//               opcode and are all forced low while rst_i is high.
// Build option: MULTICYCLE_CTRL_TRAP_EN - unknown/SYSTEM opcodes enter a
//               sticky TRAP state (trap_o=1). Without it they retire as NOPs
//               and trap_o is tied low.
// Ports       : clk_i, rst_i (sync, active-high)
//               instruction_word_i[31:0]  IR contents
//               mem_ready_i               memory handshake completion
//               branch_taken_i            ALU compare result (EXEC)
//               mem_req_o, mem_we_o, mem_addr_sel_o   memory port control
//               ir_we_o, pc_we_o, pc_src_o[1:0]       IR/PC control
//               alu_src_a_o[1:0], alu_src_b_o, alu_ctrl_o[1:0]
//               rf_we_o, wb_sel_o[1:0]                register write-back
//               retire_o, instret_o[INSTRET_W-1:0]    retirement
//               trap_o                                illegal-instr flag
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
    import riscv_pkg::*;
#(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          instruction_word_i,
    input  logic                 mem_ready_i,
    input  logic                 branch_taken_i,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic                 mem_addr_sel_o,
    output logic                 ir_we_o,
    output logic                 pc_we_o,
    output logic [1:0]           pc_src_o,
    output logic [1:0]           alu_src_a_o,
    output logic                 alu_src_b_o,
    output logic [1:0]           alu_ctrl_o,
    output logic                 rf_we_o,
    output logic [1:0]           wb_sel_o,
    output logic                 retire_o,
    output logic [INSTRET_W-1:0] instret_o,
    output logic                 trap_o
);

    ctrl_state_t          r_state;
    ctrl_state_t          w_next_state;
    logic [INSTRET_W-1:0] r_instret;
    instr_class_t         w_class;
    logic                 w_rd_nonzero;
    logic                 w_unused_ir;

    logic       w_mem_req;
    logic       w_mem_we;
    logic       w_mem_addr_sel;
    logic       w_ir_we;
    logic       w_pc_we;
    pc_src_t    w_pc_src;
    alu_src_a_t w_alu_src_a;
    logic       w_alu_src_b;
    alu_ctrl_t  w_alu_ctrl;
    logic       w_rf_we;
    wb_sel_t    w_wb_sel;
    logic       w_retire;

    ctrl_opcode_dec u_opcode_dec (
        .i_opcode (instruction_word_i[6:0]),
        .o_class  (w_class)
    );

    assign w_rd_nonzero = (instruction_word_i[11:7] != 5'd0);
    // Only opcode and rd steer control; the remaining fields go to the datapath.
    assign w_unused_ir  = ^instruction_word_i[31:12];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + INSTRET_W'(1);
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_mem_req      = 1'b0;
        w_mem_we       = 1'b0;
        w_mem_addr_sel = 1'b0;
        w_ir_we        = 1'b0;
        w_pc_we        = 1'b0;
        w_pc_src       = PC_SRC_PLUS4;
        w_alu_src_a    = SRC_A_RS1;
        w_alu_src_b    = SRC_B_RS2;
        w_alu_ctrl     = ALU_CTRL_ADD;
        w_rf_we        = 1'b0;
        w_wb_sel       = WB_SEL_ALU;
        w_retire       = 1'b0;

        case (r_state)
            ST_FETCH: begin
                w_mem_req = 1'b1;
                if (mem_ready_i) begin
                    w_ir_we      = 1'b1;
                    w_next_state = ST_DECODE;
                end
            end

            // Register-file read and immediate generation settle here.
            ST_DECODE: begin
                w_next_state = ST_EXEC;
            end

            ST_EXEC: begin
                if (w_class.op || w_class.op_imm) begin
                    w_alu_ctrl   = ALU_CTRL_FUNCT;
                    w_alu_src_b  = w_class.op_imm ? SRC_B_IMM : SRC_B_RS2;
                    w_next_state = ST_WB;
                end else if (w_class.lui) begin
                    w_alu_src_a  = SRC_A_ZERO;
                    w_alu_src_b  = SRC_B_IMM;
                    w_next_state = ST_WB;
                end else if (w_class.auipc) begin
                    w_alu_src_a  = SRC_A_PC;
                    w_alu_src_b  = SRC_B_IMM;
                    w_next_state = ST_WB;
                end else if (w_class.load || w_class.store) begin
                    // Effective address rs1 + imm is captured for MEM.
                    w_alu_src_b  = SRC_B_IMM;
                    w_next_state = ST_MEM;
                end else if (w_class.branch) begin
                    w_alu_ctrl   = ALU_CTRL_BRANCH;
                    w_pc_we      = 1'b1;
                    w_pc_src     = branch_taken_i ? PC_SRC_IMM : PC_SRC_PLUS4;
                    w_retire     = 1'b1;
                    w_next_state = ST_FETCH;
                end else if (w_class.jal || w_class.jalr) begin
                    // rs1 + imm is the JALR target; JAL takes PC + imm in WB.
                    w_alu_src_b  = SRC_B_IMM;
                    w_next_state = ST_WB;
                end else if (w_class.fence) begin
                    w_pc_we      = 1'b1;
                    w_retire     = 1'b1;
                    w_next_state = ST_FETCH;
                end else if (is_unsupported(w_class)) begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
                    w_next_state = ST_TRAP;
`else
                    w_pc_we      = 1'b1;
                    w_retire     = 1'b1;
                    w_next_state = ST_FETCH;
`endif
                end else begin
                    w_next_state = ST_FETCH;
                end
            end

            ST_MEM: begin
                w_mem_req      = 1'b1;
                w_mem_addr_sel = 1'b1;
                w_mem_we       = w_class.store;
                if (mem_ready_i) begin
                    if (w_class.store) begin
                        w_pc_we      = 1'b1;
                        w_retire     = 1'b1;
                        w_next_state = ST_FETCH;
                    end else begin
                        w_next_state = ST_WB;
                    end
                end
            end

            ST_WB: begin
                w_rf_we = w_rd_nonzero;
                if (w_class.load) begin
                    w_wb_sel = WB_SEL_MEM;
                end else if (w_class.jal || w_class.jalr) begin
                    w_wb_sel = WB_SEL_PC4;
                end
                w_pc_we = 1'b1;
                if (w_class.jal) begin
                    w_pc_src = PC_SRC_IMM;
                end else if (w_class.jalr) begin
                    w_pc_src = PC_SRC_ALU;
                end
                w_retire     = 1'b1;
                w_next_state = ST_FETCH;
            end

`ifdef MULTICYCLE_CTRL_TRAP_EN
            // Parked with every write disabled until reset.
            ST_TRAP: begin
                w_next_state = ST_TRAP;
            end
`endif

            default: begin
                w_next_state = ST_FETCH;
            end
        endcase
    end

    // Reset overrides every strobe so an aborted instruction writes nothing.
    assign mem_req_o      = w_mem_req      & ~rst_i;
    assign mem_we_o       = w_mem_we       & ~rst_i;
    assign mem_addr_sel_o = w_mem_addr_sel & ~rst_i;
    assign ir_we_o        = w_ir_we        & ~rst_i;
    assign pc_we_o        = w_pc_we        & ~rst_i;
    assign pc_src_o       = rst_i ? 2'd0 : w_pc_src;
    assign alu_src_a_o    = rst_i ? 2'd0 : w_alu_src_a;
    assign alu_src_b_o    = w_alu_src_b    & ~rst_i;
    assign alu_ctrl_o     = rst_i ? 2'd0 : w_alu_ctrl;
    assign rf_we_o        = w_rf_we        & ~rst_i;
    assign wb_sel_o       = rst_i ? 2'd0 : w_wb_sel;
    assign retire_o       = w_retire       & ~rst_i;
    assign instret_o      = rst_i ? '0 : r_instret;

`ifdef MULTICYCLE_CTRL_TRAP_EN
    assign trap_o = (r_state == ST_TRAP) & ~rst_i;
`else
    assign trap_o = 1'b0;
`endif

endmodule
`default_nettype wire
